// File: rtl/sm3_compress.sv
// sm3_compress: iterative SM3 compression engine, one round per clock.
//
// Accepts one padded 512-bit block and runs ROUNDS compression rounds on it.
// The 16-word message schedule is expanded on the fly in a sliding window.
// The chained 256-bit digest is then presented at the output.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid / in_ready   block handshake; in_ready is high only in IDLE
//   in_block [511:0]      W0 in bits 511:480 ... W15 in bits 31:0
//   in_first              1 = chain from IV, 0 = chain from the digest register
//   out_valid / out_ready digest handshake; out_valid is high only in DONE
//   out_digest [255:0]    A in bits 255:224 ... H in bits 31:0
//   busy                  high while rounds are running
//   dbg_round/dbg_ss1/dbg_ss2   round index and SS1/SS2 of the current round;
//                               present only when SM3_ROUND_TRACE_EN is defined
//
// States:
//   state | meaning
//   IDLE  | waiting for a block, in_ready=1
//   RUN   | executing rounds j=0..ROUNDS-1
//   DONE  | digest held, out_valid=1
module sm3_compress #(
   parameter int ROUNDS = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [511:0] in_block,
   input  logic         in_first,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_digest,
   output logic         busy
`ifdef SM3_ROUND_TRACE_EN
   ,
   output logic [5:0]   dbg_round,
   output logic [31:0]  dbg_ss1,
   output logic [31:0]  dbg_ss2
`endif
);

   localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
   localparam logic [5:0]   LAST = 6'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nxt;
   logic [31:0]   a, b, c, d, e, f, g, h;
   logic [31:0]   w [16];
   logic [5:0]    j;
   logic [255:0]  digest;
   logic [255:0]  v_load;

   logic [31:0]   a12, tj, ss1, ss2, ff, gg, tt1, tt2, w_new;

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
      logic [63:0] t;
      t = {x, x} << n;
      return t[63:32];
   endfunction

   function automatic logic [31:0] p0(input logic [31:0] x);
      return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
   endfunction

   function automatic logic [31:0] p1(input logic [31:0] x);
      return x ^ rotl(x, 5'd15) ^ rotl(x, 5'd23);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)    state_nxt = RUN;
         RUN:     if (j == LAST)   state_nxt = DONE;
         DONE:    if (out_ready)   state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign busy       = (state == RUN);
   assign out_digest = digest;
   assign v_load     = in_first ? IV : digest;

   always_comb begin
      a12 = rotl(a, 5'd12);
      tj  = (j < 6'd16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rotl(a12 + e + rotl(tj, j[4:0]), 5'd7);
      ss2 = ss1 ^ a12;
      if (j < 6'd16) begin
         ff = a ^ b ^ c;
         gg = e ^ f ^ g;
      end else begin
         ff = (a & b) | (a & c) | (b & c);
         gg = (e & f) | (~e & g);
      end
      tt1   = ff + d + ss2 + (w[0] ^ w[4]);
      tt2   = gg + h + ss1 + w[0];
      w_new = p1(w[0] ^ w[7] ^ rotl(w[13], 5'd15)) ^ rotl(w[3], 5'd7) ^ w[10];
   end

   // The digest register takes V on accept, so the final XOR needs no separate
   // copy of V; with in_first=0 it simply keeps its chained value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {a, b, c, d, e, f, g, h} <= '0;
         for (int i = 0; i < 16; i++) w[i] <= '0;
         j      <= '0;
         digest <= IV;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               {a, b, c, d, e, f, g, h} <= v_load;
               digest <= v_load;
               for (int i = 0; i < 16; i++) w[i] <= in_block[511 - 32*i -: 32];
               j <= '0;
            end
            RUN: begin
               a <= tt1;
               b <= a;
               c <= rotl(b, 5'd9);
               d <= c;
               e <= p0(tt2);
               f <= e;
               g <= rotl(f, 5'd19);
               h <= g;
               for (int i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15] <= w_new;
               if (j == LAST) begin
                  j      <= '0;
                  digest <= digest ^ {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g};
               end else begin
                  j <= j + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SM3_ROUND_TRACE_EN
   assign dbg_round = busy ? j   : 6'd0;
   assign dbg_ss1   = busy ? ss1 : 32'd0;
   assign dbg_ss2   = busy ? ss2 : 32'd0;
`endif

endmodule

// File: tb/tb_sm3_compress.sv
module tb_sm3_compress;

   localparam logic [255:0] IV      = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
   localparam logic [255:0] ABC_DIG = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
   localparam logic [255:0] TWO_DIG = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [511:0] in_block = '0;
   logic         in_first = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [255:0] out_digest;
   logic         busy;
`ifdef SM3_ROUND_TRACE_EN
   logic [5:0]   dbg_round;
   logic [31:0]  dbg_ss1, dbg_ss2;
`endif

   int checks = 0;
   int errors = 0;

   logic [511:0] blk_abc, blk_abcd, blk_pad;
   int           ncyc;

   sm3_compress dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_block   (in_block),
      .in_first   (in_first),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_digest (out_digest),
      .busy       (busy)
`ifdef SM3_ROUND_TRACE_EN
      ,
      .dbg_round  (dbg_round),
      .dbg_ss1    (dbg_ss1),
      .dbg_ss2    (dbg_ss2)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a block at a negedge while IDLE; returns after the accept edge.
   task automatic send(input logic [511:0] blk, input logic first);
      int n;
      n = 0;
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready_timeout", 256'(in_ready), 256'd1);
      in_valid = 1'b1;
      in_block = blk;
      in_first = first;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Counts edges after the accept edge until out_valid is seen.
   task automatic wait_done(output int n);
      n = 0;
      while (n < 300) begin
         @(posedge clk);
         n++;
         #1;
         if (out_valid) break;
      end
   endtask

   task automatic take();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      blk_abc  = {32'h61626380, 448'h0, 32'h00000018};
      blk_abcd = {16{32'h61626364}};
      blk_pad  = {32'h80000000, 448'h0, 32'h00000200};

      // reset state
      #12;
      chk("rst_digest",    out_digest,        IV);
      chk("rst_in_ready",  256'(in_ready),    256'd1);
      chk("rst_out_valid", 256'(out_valid),   256'd0);
      chk("rst_busy",      256'(busy),        256'd0);
      @(negedge clk);
      rst = 1'b0;

      // "abc" single block, latency
      send(blk_abc, 1'b1);
      chk("abc_busy", 256'(busy), 256'd1);
`ifdef SM3_ROUND_TRACE_EN
      chk("trace_round0", 256'(dbg_round), 256'd0);
      chk("trace_ss2",    256'(dbg_ss2),   256'(dbg_ss1 ^ 32'h0166f738));
`endif
      wait_done(ncyc);
      chk("abc_latency", 256'(ncyc), 256'd64);
      chk("abc_digest",  out_digest, ABC_DIG);
      take();
      chk("abc_back_idle", 256'(in_ready), 256'd1);

      // two-block chain
      send(blk_abcd, 1'b1);
      wait_done(ncyc);
      chk("two_latency1", 256'(ncyc), 256'd64);
      take();
      send(blk_pad, 1'b0);
      wait_done(ncyc);
      chk("two_digest", out_digest, TWO_DIG);
      take();

      // backpressure
      send(blk_abc, 1'b1);
      wait_done(ncyc);
      @(negedge clk);
      in_valid = 1'b1;
      in_block = blk_abcd;
      in_first = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("bp_digest",   out_digest,        ABC_DIG);
         chk("bp_in_ready", 256'(in_ready),    256'd0);
      end
      chk("bp_out_valid", 256'(out_valid), 256'd1);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("bp_not_taken_busy", 256'(busy),     256'd0);
      chk("bp_idle_ready",     256'(in_ready), 256'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("bp_accept_next", 256'(busy), 256'd1);
      wait_done(ncyc);
      chk("bp_abcd_latency", 256'(ncyc), 256'd64);
      take();

      // reset at round 30 after chaining from a non-IV digest
      send(blk_abc, 1'b0);
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1 chk("mid_no_valid", 256'(out_valid), 256'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_digest", out_digest,     IV);
      chk("mid_rst_busy",   256'(busy),     256'd0);
      chk("mid_rst_ready",  256'(in_ready), 256'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 chk("mid_rst_no_valid", 256'(out_valid), 256'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      send(blk_abc, 1'b0);
      wait_done(ncyc);
      chk("resend_latency", 256'(ncyc), 256'd64);
      chk("resend_digest",  out_digest, ABC_DIG);
      take();

      // in_valid toggling with junk blocks while running
      send(blk_abc, 1'b1);
      ncyc = 0;
      while (ncyc < 300) begin
         @(negedge clk);
         if (out_valid) break;
         in_valid = 1'($urandom_range(0, 1));
         in_block = {16{$urandom()}};
         in_first = 1'($urandom_range(0, 1));
         ncyc++;
      end
      in_valid = 1'b0;
      chk("toggle_done",   256'(out_valid), 256'd1);
      chk("toggle_digest", out_digest,      ABC_DIG);
      take();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
